// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two FIFO of {pc, instr} entries with synchronous flush.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  fetch_entry_t             i_data,
  input  logic                     i_pop,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == {CW{1'b0}});
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  // Entry storage, cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !i_flush) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers and occupancy; a flush discards everything queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (i_flush) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers responses, flushes on redirect.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  input  logic        ifid_ready,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  fq_state_e    r_state;
  fq_state_e    w_next_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_inflight_pc;
  logic         r_inflight;
  logic         w_issue;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic [CW-1:0] w_count;
  logic         w_full;
  logic         w_empty;
  logic [CW:0]  w_occupancy;
  fetch_entry_t w_push_data;
  fetch_entry_t w_head;

  // An issued request owns a slot until its response lands, so the queue cannot overflow.
  assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_push_data = '{pc: r_inflight_pc, instr: imem_rdata};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= BOOT;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      BOOT:    w_next_state = RUN;
      RUN:     w_next_state = (redirect && r_inflight) ? DRAIN : RUN;
      DRAIN:   w_next_state = RUN;
      default: w_next_state = BOOT;
    endcase
  end

  // Control outputs; responses only land in RUN outside a redirect cycle.
  always_comb begin
    w_issue = 1'b0;
    w_push  = 1'b0;
    case (r_state)
      RUN: begin
        w_issue = !redirect && !w_full && (w_occupancy < DEPTH_OCC);
        w_push  = imem_rvalid && !redirect;
      end
      BOOT, DRAIN: begin
        w_issue = 1'b0;
        w_push  = 1'b0;
      end
      default: begin
        w_issue = 1'b0;
        w_push  = 1'b0;
      end
    endcase
  end

  assign w_flush = redirect;
  assign w_pop   = !w_empty && ifid_ready && !redirect;

  // Fetch PC and the PC of the single outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= 32'h0000_0000;
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (redirect) begin
        r_fetch_pc <= redirect_pc & ~32'h0000_0003;
      end else if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + INSTR_BYTES;
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign imem_req   = w_issue;
  assign imem_addr  = r_fetch_pc;
  assign ifid_valid = !w_empty;
  assign ifid_pc    = w_head.pc;
  assign ifid_instr = w_head.instr;

`ifdef FETCH_STATS_EN
  logic [31:0] w_flush_amt;

  // A pop coinciding with redirect was consumed, so it is not counted as flushed.
  assign w_flush_amt = 32'(w_count) - 32'(!w_empty && ifid_ready) + 32'(r_inflight);

  // Saturating push and flush counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetched <= 32'h0000_0000;
      stat_flushed <= 32'h0000_0000;
    end else begin
      if (w_push)  stat_fetched <= sat_add32(stat_fetched, 32'd1);
      if (w_flush) stat_flushed <= sat_add32(stat_flushed, w_flush_amt);
    end
  end
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets the queue entry count; legal values are powers of two from 2 to 16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: imem_req  output  1  fetch request strobe to instruction memory.
REQ-006 Port: imem_addr  output  32  fetch byte address, word-aligned.
REQ-007 Port: imem_rvalid  input  1  response strobe, one cycle after the corresponding imem_req.
REQ-008 Port: imem_rdata  input  32  instruction word returned with imem_rvalid.
REQ-009 Port: redirect  input  1  branch/jump taken, so flush and refetch.
REQ-010 Port: redirect_pc  input  32  target address; bits [1:0] are ignored (forced to 0).
REQ-011 Port: ifid_valid  output  1  head entry is valid for the decode stage.
REQ-012 Port: ifid_ready  input  1  decode accepts the head entry this cycle.
REQ-013 Port: ifid_pc  output  32  PC of the head entry.
REQ-014 Port: ifid_instr  output  32  instruction of the head entry.

Function
REQ-015 The queue SHALL hold {pc, instr} pairs in FIFO order; a pop occurs when ifid_valid && ifid_ready.
REQ-016 The FSM SHALL have three states: BOOT, RUN and DRAIN. BOOT goes to RUN after 1 cycle. RUN goes to DRAIN on redirect while a request is in flight. RUN stays in RUN on redirect with nothing in flight. DRAIN goes to RUN after 1 cycle.
REQ-017 In RUN, imem_req SHALL assert when (count + inflight) < DEPTH; imem_addr SHALL equal fetch_pc.
REQ-018 fetch_pc SHALL increment by 4 on each issued request, wrapping modulo 2^32 (32'hFFFF_FFFC to 32'h0).
REQ-019 A response arriving in RUN SHALL be written to the tail with the PC of the request that produced it.
REQ-020 On redirect: queue count goes to 0, fetch_pc goes to redirect_pc & ~3, and ifid_valid is 0 the next cycle.
REQ-021 On redirect, any response arriving during DRAIN SHALL be discarded.
REQ-022 No imem_req SHALL issue in the redirect cycle, in BOOT or in DRAIN.
REQ-023 Redirect together with a pop SHALL apply the redirect only; the popped entry counts as consumed.
REQ-024 A push and a pop in the same cycle at full or empty SHALL leave count unchanged and preserve order; a push into an empty queue is visible at the head on the next cycle (latency req to ifid_valid = 2 cycles).
REQ-025 A full queue SHALL never overflow; any request issued is guaranteed a slot.
REQ-026 ifid_pc and ifid_instr SHALL hold stable while ifid_valid && !ifid_ready.

Reset
REQ-027 Reset SHALL force: state BOOT, fetch_pc = RESET_PC, count = 0, inflight = 0, imem_req = 0, imem_addr = RESET_PC, ifid_valid = 0, ifid_pc = 0, ifid_instr = 0.
REQ-028 A response arriving in the first cycle after reset deassertion SHALL be discarded.

Configuration
REQ-029 With FETCH_STATS_EN defined, the block SHALL add two 32-bit outputs: stat_fetched, which counts pushes, and stat_flushed, which counts entries plus in-flight requests discarded by redirect. Both saturate at 32'hFFFF_FFFF and reset to 0.
REQ-030 Without FETCH_STATS_EN, those ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (BOOT/RUN/DRAIN), the fetch-entry struct {pc[31:0], instr[31:0]} and the constant INSTR_BYTES = 4.
REQ-032 The storage SHALL be one sub-module, fetch_fifo (parameterised by DEPTH, with push/pop/count/full/empty); the FSM and PC logic stay in fetch_queue.

Verification
REQ-033 Reset, then ifid_ready = 1 with the memory returning addr>>2: imem_addr sequence 0, 4, 8; ifid_valid first rises in cycle 3; ifid_pc/instr = 0/0, 4/1, 8/2.
REQ-034 ifid_ready = 0 for 10 cycles, DEPTH = 4: exactly 4 requests issue (0x0 to 0xC), then imem_req stays 0; releasing ready gives ordered output 0x0, 0x4, 0x8, 0xC with no loss.
REQ-035 Redirect with redirect_pc = 32'h0000_0103 while one request is in flight: the in-flight response is dropped, the next imem_addr is 0x100, and the next ifid_pc is 0x100.
REQ-036 Redirect in the same cycle as a pop at count = 3: the next cycle has ifid_valid = 0 and count = 0, and the stale PC never appears.
REQ-037 RESET_PC = 32'hFFFF_FFF8: imem_addr sequence FFF8, FFFC, 0000, 0004.
REQ-038 With FETCH_STATS_EN, 6 pushes then a redirect with 2 queued + 1 in flight: stat_fetched = 6, stat_flushed = 3. Asserting reset mid-run clears both counters and ifid_valid asynchronously.
